// File: rtl/oled_frame_arbiter.sv
// oled_frame_arbiter: shares the 96x64 OLED pixel stream between requesters.
// Tracks pixel coordinates incrementally from the driver's sample strobes,
// cross-checks them against pixel_index, and grants display ownership
// round-robin, switching owners only at frame boundaries.
module oled_frame_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WIDTH       = 96,
  parameter int unsigned HEIGHT      = 64,
  parameter int unsigned HOLD_FRAMES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_begin,
  input  logic                 sample_pixel,
  input  logic [12:0]          pixel_index,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  color_in,
  output logic [15:0]          pixel_data,
  output logic [7:0]           pos_x,
  output logic [6:0]           pos_y,
  output logic [N_REQ-1:0]     grant,
  output logic                 frame_done,
  output logic                 sync_err
);

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  // Coordinate tracking
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [12:0] idx_q, idx_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // Arbiter
  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  hold_q, hold_d;

  logic [1:0]       scan_base;
  logic [1:0]       scan_pick;
  logic             scan_found;
  logic [N_REQ-1:0] owner_vec;
  logic             owner_req;
  logic             other_req;
  logic             rearb;

  // Next-state for the x/y/idx counters, frame_done pulse and sticky sync flag
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    idx_d  = idx_q;
    done_d = 1'b0;
    err_d  = err_q;
    if (frame_begin) begin
      // frame_begin overrides a coincident sample: no increment, no check
      x_d   = '0;
      y_d   = '0;
      idx_d = '0;
    end else if (sample_pixel) begin
      if (pixel_index != idx_q) begin
        err_d = 1'b1;
      end
      if (x_q == 8'(WIDTH - 1)) begin
        x_d = '0;
        if (y_q == 7'(HEIGHT - 1)) begin
          y_d    = '0;
          idx_d  = '0;
          done_d = 1'b1;
        end else begin
          y_d   = y_q + 7'd1;
          idx_d = idx_q + 13'd1;
        end
      end else begin
        x_d   = x_q + 8'd1;
        idx_d = idx_q + 13'd1;
      end
    end
  end

  // Counter and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      idx_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // One-hot owner vector and owner/other request status
  always_comb begin
    owner_vec = '0;
    owner_req = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (owner_q == 2'(i)) begin
        owner_vec[i] = 1'b1;
        owner_req    = req[i];
      end
    end
    other_req = |(req & ~owner_vec);
  end

  // Round-robin scan: first set request strictly after scan_base, wrapping
  // around; two ascending passes avoid a variable modulo index
  always_comb begin
    scan_base  = (state_q == OWNED) ? owner_q : last_q;
    scan_found = 1'b0;
    scan_pick  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!scan_found && req[i] && (i > 32'(scan_base))) begin
        scan_found = 1'b1;
        scan_pick  = 2'(i);
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!scan_found && req[i] && (i <= 32'(scan_base))) begin
        scan_found = 1'b1;
        scan_pick  = 2'(i);
      end
    end
  end

  // Arbiter next-state: decisions are taken only on frame_begin
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    rearb   = !owner_req || ((hold_q >= 8'(HOLD_FRAMES)) && other_req);
    if (frame_begin) begin
      case (state_q)
        IDLE: begin
          if (scan_found) begin
            state_d = OWNED;
            owner_d = scan_pick;
            last_d  = scan_pick;
            hold_d  = 8'd1;
          end
        end
        OWNED: begin
          if (rearb) begin
            if (scan_found) begin
              owner_d = scan_pick;
              last_d  = scan_pick;
              hold_d  = 8'd1;
            end else begin
              state_d = IDLE;
            end
          end else if (hold_q != 8'hFF) begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbiter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 2'(N_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  // Output mux: owner's colour and grant, black and no grant when idle
  always_comb begin
    pixel_data = '0;
    grant      = '0;
    if (state_q == OWNED) begin
      grant = owner_vec;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (owner_q == 2'(i)) begin
          pixel_data = color_in[16*i +: 16];
        end
      end
    end
  end

  assign pos_x      = x_q;
  assign pos_y      = y_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;

endmodule

// File: tb/tb_oled_frame_arbiter.sv
// Directed scoreboard bench for oled_frame_arbiter.
module tb_oled_frame_arbiter;

  localparam int K_POS  = 0;
  localparam int K_GNT  = 1;
  localparam int K_PIX  = 2;
  localparam int K_DONE = 3;
  localparam int K_SYNC = 4;

  logic        clk;
  logic        rst_n;
  logic        frame_begin;
  logic        sample_pixel;
  logic [12:0] pixel_index;
  logic [3:0]  req;
  logic [63:0] color_in;
  logic [15:0] pixel_data;
  logic [7:0]  pos_x;
  logic [6:0]  pos_y;
  logic [3:0]  grant;
  logic        frame_done;
  logic        sync_err;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference coordinate model
  logic [7:0]  mx;
  logic [6:0]  my;
  logic [12:0] midx;

  oled_frame_arbiter #(
    .N_REQ(4),
    .WIDTH(96),
    .HEIGHT(64),
    .HOLD_FRAMES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_begin(frame_begin),
    .sample_pixel(sample_pixel),
    .pixel_index(pixel_index),
    .req(req),
    .color_in(color_in),
    .pixel_data(pixel_data),
    .pos_x(pos_x),
    .pos_y(pos_y),
    .grant(grant),
    .frame_done(frame_done),
    .sync_err(sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_POS:   return {17'd0, pos_y, pos_x};
      K_GNT:   return {28'd0, grant};
      K_PIX:   return {16'd0, pixel_data};
      K_DONE:  return {31'd0, frame_done};
      default: return {31'd0, sync_err};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.kind);
      checks++;
      assert (o === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fb();
    frame_begin = 1'b1;
    tick();
    frame_begin = 1'b0;
    mx   = '0;
    my   = '0;
    midx = '0;
  endtask

  task automatic do_sample(input logic [12:0] pidx);
    logic last_px;
    last_px      = (mx == 8'd95) && (my == 7'd63);
    sample_pixel = 1'b1;
    pixel_index  = pidx;
    tick();
    sample_pixel = 1'b0;
    if (mx == 8'd95) begin
      mx = '0;
      my = (my == 7'd63) ? 7'd0 : my + 7'd1;
    end else begin
      mx = mx + 8'd1;
    end
    midx = last_px ? 13'd0 : midx + 13'd1;
    push("pos", K_POS, {17'd0, my, mx});
    push("frame_done", K_DONE, {31'd0, last_px});
    drain();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    mx   = '0;
    my   = '0;
    midx = '0;
  endtask

  initial begin
    rst_n        = 1'b0;
    frame_begin  = 1'b0;
    sample_pixel = 1'b0;
    pixel_index  = '0;
    req          = '0;
    color_in     = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    mx = '0; my = '0; midx = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_pos", K_POS, 32'd0);
    push("rst_grant", K_GNT, 32'd0);
    push("rst_pix", K_PIX, 32'd0);
    push("rst_done", K_DONE, 32'd0);
    push("rst_sync", K_SYNC, 32'd0);
    drain();
    rst_n = 1'b1;
    tick();

    // Full frame with no requesters: coordinate walk and frame_done
    fb();
    push("idle_pos", K_POS, 32'd0);
    push("idle_grant", K_GNT, 32'd0);
    push("idle_pix", K_PIX, 32'd0);
    drain();
    for (int i = 0; i < 6144; i++) do_sample(midx);
    tick();
    push("done_drop", K_DONE, 32'd0);
    push("frame_sync", K_SYNC, 32'd0);
    drain();

    // frame_begin and sample_pixel together at (40,10)
    fb();
    for (int i = 0; i < 1000; i++) do_sample(midx);
    push("pos_40_10", K_POS, {17'd0, 7'd10, 8'd40});
    drain();
    frame_begin  = 1'b1;
    sample_pixel = 1'b1;
    pixel_index  = 13'h1abc;
    tick();
    frame_begin  = 1'b0;
    sample_pixel = 1'b0;
    mx = '0; my = '0; midx = '0;
    push("collide_pos", K_POS, 32'd0);
    push("collide_sync", K_SYNC, 32'd0);
    drain();
    do_sample(13'd0);
    push("collide_idx0", K_SYNC, 32'd0);
    push("collide_step", K_POS, {17'd0, 7'd0, 8'd1});
    drain();

    // Round-robin with hold: requesters 1 and 2
    reset_pulse();
    req = 4'b0110;
    fb();
    push("grant_r1", K_GNT, 32'h2);
    push("pix_r1", K_PIX, 32'h2222);
    drain();
    for (int f = 2; f <= 8; f++) begin
      repeat (3) do_sample(midx);
      fb();
      push("hold_r1", K_GNT, 32'h2);
      drain();
    end
    repeat (3) do_sample(midx);
    fb();
    push("grant_r2", K_GNT, 32'h4);
    push("pix_r2", K_PIX, 32'h3333);
    drain();

    // Owner 2 drops request mid-frame
    repeat (3) do_sample(midx);
    req = 4'b0010;
    repeat (3) do_sample(midx);
    push("drop_keep_g", K_GNT, 32'h4);
    push("drop_keep_p", K_PIX, 32'h3333);
    drain();
    fb();
    push("drop_next_g", K_GNT, 32'h2);
    push("drop_next_p", K_PIX, 32'h2222);
    drain();
    req = 4'b0000;
    repeat (2) do_sample(midx);
    push("drop_all_keep", K_GNT, 32'h2);
    drain();
    fb();
    push("to_idle_g", K_GNT, 32'h0);
    push("to_idle_p", K_PIX, 32'h0);
    drain();

    // Sync error on a single mismatched sample, sticky across frames
    fb();
    repeat (5) do_sample(midx);
    push("sync_clean", K_SYNC, 32'd0);
    drain();
    do_sample(13'(midx + 13'd1));
    push("sync_set", K_SYNC, 32'd1);
    drain();
    fb();
    repeat (4) do_sample(midx);
    push("sync_sticky", K_SYNC, 32'd1);
    drain();

    // Asynchronous reset mid-frame while owned
    req = 4'b1000;
    fb();
    push("own_r3", K_GNT, 32'h8);
    drain();
    req = 4'b1001;
    for (int i = 0; i < 2930; i++) do_sample(midx);
    push("pos_50_30", K_POS, {17'd0, 7'd30, 8'd50});
    push("pre_rst_g", K_GNT, 32'h8);
    push("pre_rst_p", K_PIX, 32'h4444);
    drain();
    #2;
    rst_n = 1'b0;
    #1;
    mx = '0; my = '0; midx = '0;
    push("arst_pos", K_POS, 32'd0);
    push("arst_grant", K_GNT, 32'd0);
    push("arst_pix", K_PIX, 32'd0);
    push("arst_sync", K_SYNC, 32'd0);
    drain();
    #1;
    rst_n = 1'b1;
    tick();
    push("post_rst_g", K_GNT, 32'd0);
    push("post_rst_p", K_PIX, 32'd0);
    drain();
    fb();
    push("first_r0_g", K_GNT, 32'h1);
    push("first_r0_p", K_PIX, 32'h1111);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oled_frame_arbiter.md
# oled_frame_arbiter

Shares the 96x64 OLED pixel stream between up to N_REQ drawing requesters (waveform, menu, game layers) and sequences the pixel coordinates they draw against. It tracks the OLED driver's pixel strobes with incremental x/y counters, so no divider is needed. It cross-checks those counters against the driver's pixel_index. It grants display ownership round-robin, and ownership changes only at frame boundaries so no frame is ever torn between two requesters. The block sits between the OLED driver and the layer generators.

## Interface
- N_REQ, 4, number of requesters (2..4); the owner index is 2 bits
- WIDTH, 96, pixels per row
- HEIGHT, 64, rows per frame
- HOLD_FRAMES, 8, minimum frames an owner keeps the grant while still requesting (1..255)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- frame_begin  in  1  one-cycle pulse from the OLED driver at start of frame
- sample_pixel  in  1  one-cycle pulse when the driver samples pixel_data; the driver then advances pixel_index
- pixel_index  in  13  driver's current pixel index, used only for the sync check
- req  in  N_REQ  per-requester ownership request, level
- color_in  in  16*N_REQ  RGB565 colour from each requester; requester i drives bits [16i+15:16i]
- pixel_data  out  16  colour to the OLED driver
- pos_x  out  8  column of the pixel being drawn, 0..WIDTH-1
- pos_y  out  7  row of the pixel being drawn, 0..HEIGHT-1
- grant  out  N_REQ  one-hot current owner; all zero when idle
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is sampled
- sync_err  out  1  sticky flag for a counter/pixel_index mismatch

## Operation
- Coordinate counters, all registered:
  - x, y and idx (13 bits) are cleared by frame_begin.
  - On sample_pixel: x increments. At x==WIDTH-1, x wraps to 0 and y increments. At x==WIDTH-1 and y==HEIGHT-1, all counters wrap to 0.
  - idx increments on every sample_pixel and wraps to 0 together with x and y.
  - pos_x = x and pos_y = y.
- Sync check: on sample_pixel, if pixel_index != idx, set sync_err. It stays set until reset.
- frame_done pulses in the cycle after the sample_pixel that sampled the last pixel (x=WIDTH-1, y=HEIGHT-1).
- Arbiter FSM states: IDLE and OWNED. Registers: owner (2 bits), last (2 bits), hold (8 bits, saturating).
  - IDLE, on frame_begin:
    - If any req is set, pick the first set req scanning from last+1 (modulo N_REQ).
    - Go to OWNED with owner = last = that requester and hold = 1.
    - With no req set, remain in IDLE.
  - OWNED, on frame_begin:
    - The grant re-arbitrates when req[owner] is low, or when hold >= HOLD_FRAMES and another req is set.
    - Re-arbitration is the same round-robin scan starting after owner.
    - If the scan finds a requester: new owner, last = new owner, hold = 1.
    - If no req is set: go to IDLE.
    - Otherwise (no re-arbitration): hold increments, saturating at 255.
  - A req edge between frame boundaries has no effect until the next frame_begin. A dropped req still keeps its grant to the end of the frame.
- Outputs:
  - pixel_data = color_in[owner] when OWNED, 16'h0000 (black) when IDLE. This is a combinational mux off the registered owner.
  - grant = one-hot(owner) when OWNED, else 0.
- Priority: frame_begin together with sample_pixel in the same cycle means frame_begin wins. The counters clear and that sample is ignored: no increment and no sync check.

## Timing
- Reset values: pos_x=0, pos_y=0, idx=0, grant=0, pixel_data=0, frame_done=0, sync_err=0. FSM goes to IDLE with last=N_REQ-1, so that requester 0 is scanned first, and hold=0.
- Assertion of rst_n mid-frame clears everything immediately, asynchronously. The block then stays IDLE and black until the next frame_begin.
- Counters update in the cycle after the sample_pixel or frame_begin strobe. A requester has from that point until the next sample_pixel to present color_in for (pos_x, pos_y).
- Grant and owner change in the cycle after frame_begin. pixel_data switches in that same cycle, before the first sample of the frame.
- frame_done: one cycle wide, one cycle after the last sample.
- No latency beyond one register stage. The block accepts back-to-back sample_pixel strobes, one per clock.

## Test plan
- Reset, then frame_begin followed by 6144 sample_pixel pulses, with pixel_index following idx:
  - pos_x/pos_y step (0,0)->(95,0)->(0,1) … (95,63).
  - frame_done pulses exactly once, one cycle after the 6144th sample.
  - sync_err stays 0.
- req=4'b0110 from reset, then frame_begin:
  - grant=4'b0010 and pixel_data=color_in[1] in the cycle after.
  - With HOLD_FRAMES=8, the grant stays on requester 1 for 8 frames, then moves to 4'b0100 at the 9th frame_begin.
- Owner is 2; drop req[2] mid-frame:
  - grant stays on requester 2 until the next frame_begin.
  - It then moves to the next set req in round-robin order, or to IDLE with pixel_data=0 if no req is set.
- pixel_index held 1 ahead of idx on one sample:
  - sync_err rises the next cycle and stays 1 through later frames until rst_n.
- frame_begin and sample_pixel asserted in the same cycle at pos (40,10):
  - pos returns to (0,0) with no increment; idx=0.
- rst_n pulsed low at pos (50,30) while OWNED:
  - pos_x=pos_y=0, grant=0 and pixel_data=0 immediately.
  - The next frame_begin grants req 0 first if it is set.
